mbist_addr_seq: RTL and testbench
=================================

MBIST_ADDR_SEQ -- requirements
Module: mbist_addr_seq

Interface
REQ-001 SHALL have parameter BIST_ADDR_WD, default 9, address width.
REQ-002 SHALL have parameter BIST_COL_WD, default 3, column-field width (low bits of the logical address); legal range 1..BIST_ADDR_WD-1.
REQ-003 SHALL have parameter BIST_ADDR_START, default 9'h000, reset start address.
REQ-004 SHALL have parameter BIST_ADDR_END, default 9'h1F8, reset end address.
REQ-005 SHALL have ports:
- clk  in  1  clock; one clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  sequencer enable.
- step  in  1  advance address this cycle.
- updown  in  1  1 = ascending, 0 = descending.
- mode  in  2  address mode.
- bist_load  in  1  reload the first address.
- bist_shift  in  1  scan-shift enable.
- sdi  in  1  scan data in.
- sdo  out  1  scan data out.
- bist_addr  out  BIST_ADDR_WD  physical address.
- last_addr  out  1  current address is the terminal address of the pass.
- pass_done  out  1  one-cycle pulse when a pass wraps.
- busy  out  1  FSM is in RUN.
- cfg_err  out  1  start_addr > end_addr.

Function
REQ-006 SHALL hold a logical counter lcnt, a complement phase bit cph, and an FSM with states IDLE and RUN.
REQ-007 IDLE->RUN SHALL occur when run=1; on entry, lcnt = (updown ? start_addr : end_addr) and cph = 0.
REQ-008 RUN->IDLE SHALL occur when run=0; lcnt and cph SHALL hold, and step SHALL be ignored in IDLE.
REQ-009 bist_load SHALL reload lcnt = first address and clear cph in any state, taking priority over step; the state SHALL be unchanged.
REQ-010 In RUN with step=1, lcnt SHALL advance by +1 (updown=1) or -1 (updown=0), modulo 2^BIST_ADDR_WD.
REQ-011 In mode 2, step SHALL first toggle cph 0->1 without moving lcnt; the next step SHALL clear cph and advance lcnt.
REQ-012 In RUN, step at the terminal address SHALL wrap lcnt to the first address, clear cph, and pulse pass_done for exactly the following cycle.
  - Terminal address is end_addr when ascending, start_addr when descending.
  - In mode 2, the terminal condition also requires cph=1.
REQ-013 last_addr SHALL be combinational: lcnt == terminal address (plus cph=1 in mode 2), independent of state.
REQ-014 An updown change mid-pass SHALL take effect at the next step without a reload; the terminal comparison SHALL follow the current updown.
REQ-015 bist_addr SHALL be the combinational mapping of lcnt, with no added latency:
  - mode 0: lcnt.
  - mode 1 (fast-row): {lcnt[BIST_COL_WD-1:0], lcnt[BIST_ADDR_WD-1:BIST_COL_WD]}.
  - mode 2: cph ? ~lcnt : lcnt.
  - mode 3: as mode 0.
REQ-016 cfg_err SHALL be combinational (start_addr > end_addr); when cfg_err=1, the IDLE->RUN transition SHALL be blocked.
REQ-017 A mode change SHALL be legal only in IDLE; a mode change in RUN SHALL alter only the mapping, not lcnt.

Reset
REQ-018 While rst_n=0 at a clk edge, the block SHALL set: state = IDLE, lcnt = BIST_ADDR_START, cph = 0, pass_done = 0, start_addr = BIST_ADDR_START, end_addr = BIST_ADDR_END.
REQ-019 Reset asserted mid-RUN SHALL take effect at the next edge, with no partial pass_done.

Configuration
REQ-020 With MBIST_ADDR_SCAN_EN defined:
  - while bist_shift=1, start_addr SHALL shift right with sdi entering the MSB;
  - end_addr SHALL shift right with start_addr[0] entering the MSB;
  - sdo = end_addr[0];
  - the chain length is 2*BIST_ADDR_WD.
REQ-021 Without MBIST_ADDR_SCAN_EN:
  - start_addr and end_addr SHALL be the constant parameters;
  - bist_shift SHALL be ignored;
  - sdo SHALL be a one-flop delayed sdi, reset 0.

Structure
REQ-022 Package mbist_pkg SHALL hold the mode enum (ADDR_LINEAR=0, ADDR_FASTROW=1, ADDR_COMPL=2) and the FSM state enum.
REQ-023 Sub-module mbist_addr_map SHALL implement REQ-015 combinationally.

Verification
REQ-024 Mode 0, up, run=1, step every cycle from reset: bist_addr 0x000..0x1F8; last_addr at 0x1F8; the next step gives 0x000 with pass_done=1 for one cycle.
REQ-025 Mode 0, down: the first address is 0x1F8; last_addr at 0x000; wraps to 0x1F8.
REQ-026 Mode 1: lcnt 0x001 -> bist_addr 0x040; lcnt 0x008 -> bist_addr 0x001.
REQ-027 Mode 2, up, from 0x000: bist_addr sequence 0x000, 0x1FF, 0x001, 0x1FE.
REQ-028 Scan (macro on): shift 18 bits loading start=0x010 and end=0x020, then run up: wraps 0x020->0x010; a load of start=0x030, end=0x020 gives cfg_err=1 and busy stays 0.
REQ-029 rst_n=0 for one cycle mid-pass at lcnt 0x055: the next cycle shows bist_addr=0x000, busy=0, pass_done=0.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types for the MBIST address sequencer: address-mode and FSM state encodings.
package mbist_pkg;

    typedef enum logic [1:0] {
        ADDR_LINEAR  = 2'd0,
        ADDR_FASTROW = 2'd1,
        ADDR_COMPL   = 2'd2
    } addr_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/mbist_addr_map.sv
// Logical-to-physical address mapping; purely combinational, zero latency.
// Mode 3 is unassigned and falls back to the linear mapping.
module mbist_addr_map
    import mbist_pkg::*;
#(
    parameter int BIST_ADDR_WD = 9,
    parameter int BIST_COL_WD  = 3
) (
    input  logic [1:0]              mode,
    input  logic [BIST_ADDR_WD-1:0] lcnt,
    input  logic                    cph,
    output logic [BIST_ADDR_WD-1:0] bist_addr
);

    always_comb begin
        bist_addr = lcnt;
        case (mode)
            ADDR_FASTROW: bist_addr = {lcnt[BIST_COL_WD-1:0], lcnt[BIST_ADDR_WD-1:BIST_COL_WD]};
            ADDR_COMPL:   bist_addr = cph ? ~lcnt : lcnt;
            default:      bist_addr = lcnt;
        endcase
    end

endmodule

// File: rtl/mbist_addr_seq.sv
// MBIST address sequencer: up/down logical counter with linear, fast-row and complement-phase mapping.
// Optional scan-loadable start/end window under MBIST_ADDR_SCAN_EN; otherwise the window is fixed.
module mbist_addr_seq
    import mbist_pkg::*;
#(
    parameter int                      BIST_ADDR_WD    = 9,
    parameter int                      BIST_COL_WD     = 3,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    step,
    input  logic                    updown,
    input  logic [1:0]              mode,
    input  logic                    bist_load,
    input  logic                    bist_shift,
    input  logic                    sdi,
    output logic                    sdo,
    output logic [BIST_ADDR_WD-1:0] bist_addr,
    output logic                    last_addr,
    output logic                    pass_done,
    output logic                    busy,
    output logic                    cfg_err
);

    seq_state_e              state_q, state_d;
    logic [BIST_ADDR_WD-1:0] lcnt_q, lcnt_d;
    logic                    cph_q, cph_d;
    logic                    pass_done_q, pass_done_d;
    logic [BIST_ADDR_WD-1:0] start_addr, end_addr;
    logic [BIST_ADDR_WD-1:0] first_addr, term_addr;
    logic                    advance;

`ifdef MBIST_ADDR_SCAN_EN
    // Chain order: sdi -> start_addr MSB..LSB -> end_addr MSB..LSB -> sdo.
    logic [BIST_ADDR_WD-1:0] start_q, end_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q <= BIST_ADDR_START;
            end_q   <= BIST_ADDR_END;
        end else if (bist_shift) begin
            start_q <= {sdi, start_q[BIST_ADDR_WD-1:1]};
            end_q   <= {start_q[0], end_q[BIST_ADDR_WD-1:1]};
        end
    end

    assign start_addr = start_q;
    assign end_addr   = end_q;
    assign sdo        = end_q[0];
`else
    logic sdo_q;
    logic unused_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) sdo_q <= 1'b0;
        else        sdo_q <= sdi;
    end

    assign start_addr   = BIST_ADDR_START;
    assign end_addr     = BIST_ADDR_END;
    assign sdo          = sdo_q;
    assign unused_shift = bist_shift;
`endif

    // First/terminal addresses follow the live updown, so a direction flip needs no reload.
    assign first_addr = updown ? start_addr : end_addr;
    assign term_addr  = updown ? end_addr : start_addr;
    assign cfg_err    = start_addr > end_addr;
    assign last_addr  = (lcnt_q == term_addr) && ((mode != ADDR_COMPL) || cph_q);
    assign advance    = (state_q == ST_RUN) && run && step;
    assign busy       = (state_q == ST_RUN);
    assign pass_done  = pass_done_q;

    always_comb begin
        state_d     = state_q;
        lcnt_d      = lcnt_q;
        cph_d       = cph_q;
        pass_done_d = 1'b0;

        if (bist_load) begin
            lcnt_d = first_addr;
            cph_d  = 1'b0;
        end else if (advance) begin
            if ((mode == ADDR_COMPL) && !cph_q) begin
                cph_d = 1'b1;
            end else if (last_addr) begin
                lcnt_d      = first_addr;
                cph_d       = 1'b0;
                pass_done_d = 1'b1;
            end else begin
                lcnt_d = updown ? lcnt_q + 1'b1 : lcnt_q - 1'b1;
                cph_d  = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (run && !cfg_err) begin
                    state_d = ST_RUN;
                    lcnt_d  = first_addr;
                    cph_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lcnt_q      <= BIST_ADDR_START;
            cph_q       <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            cph_q       <= cph_d;
            pass_done_q <= pass_done_d;
        end
    end

    mbist_addr_map #(
        .BIST_ADDR_WD (BIST_ADDR_WD),
        .BIST_COL_WD  (BIST_COL_WD)
    ) u_map (
        .mode      (mode),
        .lcnt      (lcnt_q),
        .cph       (cph_q),
        .bist_addr (bist_addr)
    );

endmodule

// File: tb/tb_mbist_addr_seq.sv
// Bench for mbist_addr_seq: directed pass/wrap scenarios plus random traffic against a behavioural model.
module tb_mbist_addr_seq;

    localparam int W     = 9;
    localparam int C     = 3;
    localparam int N     = 1 << W;
    localparam int START = 'h000;
    localparam int END_A = 'h1F8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         run = 1'b0;
    logic         step = 1'b0;
    logic         updown = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic         bist_load = 1'b0;
    logic         bist_shift = 1'b0;
    logic         sdi = 1'b0;
    logic         sdo;
    logic [W-1:0] bist_addr;
    logic         last_addr;
    logic         pass_done;
    logic         busy;
    logic         cfg_err;

    int vec_cnt = 0;
    int miss_cnt = 0;
    bit chk_en = 1'b0;

    // Model state: pass position, complement phase, running flag, window registers.
    int m_l = START;
    int m_start = START;
    int m_end = END_A;
    bit m_c = 1'b0;
    bit m_busy = 1'b0;
    bit m_pd = 1'b0;
    bit m_sdo = 1'b0;

    mbist_addr_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .updown     (updown),
        .mode       (mode),
        .bist_load  (bist_load),
        .bist_shift (bist_shift),
        .sdi        (sdi),
        .sdo        (sdo),
        .bist_addr  (bist_addr),
        .last_addr  (last_addr),
        .pass_done  (pass_done),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_addr();
        if (mode == 2'd1) return ((m_l % (1 << C)) << (W - C)) | (m_l >> C);
        if (mode == 2'd2) return m_c ? (N - 1 - m_l) : m_l;
        return m_l;
    endfunction

    function automatic bit model_last();
        int term;
        term = updown ? m_end : m_start;
        return (m_l == term) && (mode != 2'd2 || m_c);
    endfunction

    function automatic bit model_sdo();
`ifdef MBIST_ADDR_SCAN_EN
        return m_end[0];
`else
        return m_sdo;
`endif
    endfunction

    always @(posedge clk) begin
        int first, nl, ns, ne;
        bit nc, nb, npd;
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_l     <= START;
            m_c     <= 1'b0;
            m_pd    <= 1'b0;
            m_start <= START;
            m_end   <= END_A;
            m_sdo   <= 1'b0;
        end else begin
            first = updown ? m_start : m_end;
            nl = m_l; nc = m_c; nb = m_busy; npd = 1'b0;
            ns = m_start; ne = m_end;
            if (bist_load) begin
                nl = first; nc = 1'b0;
            end else if (m_busy && run && step) begin
                if (mode == 2'd2 && !m_c) nc = 1'b1;
                else if (model_last()) begin nl = first; nc = 1'b0; npd = 1'b1; end
                else begin nl = updown ? (m_l + 1) % N : (m_l + N - 1) % N; nc = 1'b0; end
            end
            if (!m_busy && run && m_start <= m_end) begin
                nb = 1'b1; nl = first; nc = 1'b0;
            end else if (m_busy && !run) begin
                nb = 1'b0;
            end
`ifdef MBIST_ADDR_SCAN_EN
            if (bist_shift) begin
                ns = (m_start >> 1) | (int'(sdi) << (W - 1));
                ne = (m_end >> 1) | ((m_start & 1) << (W - 1));
            end
`endif
            m_l <= nl; m_c <= nc; m_busy <= nb; m_pd <= npd;
            m_start <= ns; m_end <= ne; m_sdo <= sdi;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("bist_addr", int'(bist_addr), model_addr());
            cmp("last_addr", int'(last_addr), int'(model_last()));
            cmp("pass_done", int'(pass_done), int'(m_pd));
            cmp("busy",      int'(busy),      int'(m_busy));
            cmp("cfg_err",   int'(cfg_err),   int'(m_start > m_end));
            cmp("sdo",       int'(sdo),       int'(model_sdo()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_last(input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (last_addr) begin found = 1'b1; break; end
        end
        cmp({nm, "_last_seen"}, int'(found), 1);
    endtask

`ifdef MBIST_ADDR_SCAN_EN
    task automatic scan_load(input logic [8:0] s, input logic [8:0] e);
        logic [17:0] v;
        v = {s, e};
        bist_shift = 1'b1;
        for (int i = 0; i < 18; i++) begin
            sdi = v[i];
            tick();
        end
        bist_shift = 1'b0;
        sdi = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_addr", int'(bist_addr), 'h000);
        cmp("rst_pass_done", int'(pass_done), 0);
        cmp("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;

        // Linear ascending pass and wrap
        run = 1'b1; step = 1'b1; updown = 1'b1; mode = 2'd0;
        wait_last("up");
        cmp("up_term_addr", int'(bist_addr), 'h1F8);
        tick();
        cmp("up_wrap_addr", int'(bist_addr), 'h000);
        cmp("up_wrap_pd", int'(pass_done), 1);
        tick();
        cmp("up_pd_clear", int'(pass_done), 0);
        cmp("up_after_wrap", int'(bist_addr), 'h001);

        // Linear descending pass
        run = 1'b0; step = 1'b0;
        tick();
        updown = 1'b0; run = 1'b1;
        tick();
        cmp("dn_first_addr", int'(bist_addr), 'h1F8);
        cmp("dn_busy", int'(busy), 1);
        step = 1'b1;
        wait_last("dn");
        cmp("dn_term_addr", int'(bist_addr), 'h000);
        tick();
        cmp("dn_wrap_addr", int'(bist_addr), 'h1F8);
        cmp("dn_wrap_pd", int'(pass_done), 1);

        // Fast-row mapping
        run = 1'b0; step = 1'b0; updown = 1'b1; mode = 2'd1;
        tick();
        run = 1'b1;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        #1 cmp("fastrow_1", int'(bist_addr), 'h040);
        step = 1'b1;
        repeat (7) tick();
        step = 1'b0;
        #1 cmp("fastrow_8", int'(bist_addr), 'h001);

        // Complement-phase mapping
        run = 1'b0; mode = 2'd2;
        tick();
        run = 1'b1;
        tick();
        cmp("compl_0", int'(bist_addr), 'h000);
        step = 1'b1;
        tick();
        cmp("compl_1", int'(bist_addr), 'h1FF);
        tick();
        cmp("compl_2", int'(bist_addr), 'h001);
        tick();
        cmp("compl_3", int'(bist_addr), 'h1FE);

        // Reset mid-pass
        run = 1'b0; step = 1'b0; mode = 2'd0; updown = 1'b1;
        tick();
        run = 1'b1;
        tick();
        step = 1'b1;
        repeat ('h55) tick();
        step = 1'b0;
        #1 cmp("mid_addr", int'(bist_addr), 'h055);
        rst_n = 1'b0; run = 1'b0;
        tick();
        cmp("mid_rst_addr", int'(bist_addr), 'h000);
        cmp("mid_rst_busy", int'(busy), 0);
        cmp("mid_rst_pd", int'(pass_done), 0);
        rst_n = 1'b1;

`ifdef MBIST_ADDR_SCAN_EN
        scan_load(9'h010, 9'h020);
        updown = 1'b1; mode = 2'd0; run = 1'b1; step = 1'b1;
        wait_last("scan");
        cmp("scan_term", int'(bist_addr), 'h020);
        tick();
        cmp("scan_wrap", int'(bist_addr), 'h010);
        cmp("scan_wrap_pd", int'(pass_done), 1);
        run = 1'b0; step = 1'b0;
        tick();
        scan_load(9'h030, 9'h020);
        cmp("scan_cfg_err", int'(cfg_err), 1);
        run = 1'b1;
        repeat (3) tick();
        cmp("scan_busy_blocked", int'(busy), 0);
        run = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            run        = ($urandom_range(0, 15) != 0);
            step       = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0) updown = ~updown;
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            bist_load  = ($urandom_range(0, 31) == 0);
            bist_shift = ($urandom_range(0, 63) == 0);
            sdi        = $urandom_range(0, 1) != 0;
            tick();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
